// File: rtl/systolic_feeder_if.sv
// Operand load stream for systolic_feeder: one beat carries column k of A and row k of B.
interface systolic_feeder_if #(
    parameter int unsigned DW = 16
) ();
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_a0;
    logic [DW-1:0] in_a1;
    logic [DW-1:0] in_b0;
    logic [DW-1:0] in_b1;

    modport master (
        output in_valid, in_a0, in_a1, in_b0, in_b1,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_a0, in_a1, in_b0, in_b1,
        output in_ready
    );
endinterface

// File: rtl/systolic_feeder.sv
// Buffers one A (2xK) / B (Kx2) operand pair, then clears the 2x2 systolic array and
// feeds it with row/column skew, pulsing done once the result has drained through.
module systolic_feeder #(
    parameter int unsigned DW    = 16,
    parameter int unsigned K     = 2,
    parameter int unsigned DRAIN = 3
) (
    input  logic             clk,
    input  logic             rst,
    systolic_feeder_if.slave ld,
    output logic [DW-1:0]    a1,
    output logic [DW-1:0]    a2,
    output logic [DW-1:0]    b1,
    output logic [DW-1:0]    b2,
    output logic             sys_rst,
    output logic             busy,
    output logic             done
);
    localparam int unsigned CW  = $clog2(K + 1);
    localparam int unsigned DCW = $clog2(DRAIN + 2);

    localparam logic [2:0] StLoad  = 3'd0;
    localparam logic [2:0] StClear = 3'd1;
    localparam logic [2:0] StFeed  = 3'd2;
    localparam logic [2:0] StDrain = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    logic [2:0]     state_q, state_d;
    logic [CW-1:0]  beat_q, beat_d;
    logic [CW-1:0]  step_q, step_d;
    logic [DCW-1:0] dcnt_q, dcnt_d;

    logic [DW-1:0]  a0_buf [K];
    logic [DW-1:0]  a1_buf [K];
    logic [DW-1:0]  b0_buf [K];
    logic [DW-1:0]  b1_buf [K];

    logic [DW-1:0]  a1_d, a2_d, b1_d, b2_d;
    logic           sys_rst_d, busy_d, done_d;
    logic           hs;

    assign ld.in_ready = (state_q == StLoad) && !rst;
    assign hs          = ld.in_valid && ld.in_ready;

    // Out-of-range indices (step K, or step 0 minus one) select nothing and yield zero.
    function automatic logic [DW-1:0] pick(input logic [DW-1:0] v [K], input logic [CW-1:0] idx);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < K; i++) begin
            if (idx == CW'(i)) r = v[i];
        end
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        step_d  = step_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            StLoad: begin
                if (hs) begin
                    if (beat_q == CW'(K - 1)) begin
                        state_d = StClear;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            StClear: begin
                state_d = StFeed;
                step_d  = '0;
            end
            StFeed: begin
                if (step_q == CW'(K)) begin
                    state_d = (DRAIN == 0) ? StDone : StDrain;
                    dcnt_d  = '0;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            StDrain: begin
                if (dcnt_q == DCW'(DRAIN - 1)) state_d = StDone;
                else                           dcnt_d  = dcnt_q + 1'b1;
            end
            StDone:  state_d = StLoad;
            default: state_d = StLoad;
        endcase
    end

    // Outputs are registered, so they are computed from the state being entered.
    always_comb begin
        a1_d      = '0;
        a2_d      = '0;
        b1_d      = '0;
        b2_d      = '0;
        sys_rst_d = (state_d == StClear);
        busy_d    = (state_d != StLoad);
        done_d    = (state_d == StDone);
        if (state_d == StFeed) begin
            a1_d = pick(a0_buf, step_d);
            b1_d = pick(b0_buf, step_d);
            if (step_d != '0) begin
                a2_d = pick(a1_buf, step_d - 1'b1);
                b2_d = pick(b1_buf, step_d - 1'b1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StLoad;
            beat_q  <= '0;
            step_q  <= '0;
            dcnt_q  <= '0;
            for (int i = 0; i < K; i++) begin
                a0_buf[i] <= '0;
                a1_buf[i] <= '0;
                b0_buf[i] <= '0;
                b1_buf[i] <= '0;
            end
            a1      <= '0;
            a2      <= '0;
            b1      <= '0;
            b2      <= '0;
            sys_rst <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            step_q  <= step_d;
            dcnt_q  <= dcnt_d;
            if (hs) begin
                for (int i = 0; i < K; i++) begin
                    if (beat_q == CW'(i)) begin
                        a0_buf[i] <= ld.in_a0;
                        a1_buf[i] <= ld.in_a1;
                        b0_buf[i] <= ld.in_b0;
                        b1_buf[i] <= ld.in_b1;
                    end
                end
            end
            a1      <= a1_d;
            a2      <= a2_d;
            b1      <= b1_d;
            b2      <= b2_d;
            sys_rst <= sys_rst_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end
endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: table of operand pairs (hand and random),
// per-cycle schedule checks plus a behavioural 2x2 array model to recover A*B.
module tb_systolic_feeder;
    localparam int unsigned DW    = 16;
    localparam int unsigned K     = 2;
    localparam int unsigned DRAIN = 3;
    localparam int          RUN   = K + 4 + DRAIN;  // cycle index of the LOAD after DONE
    localparam int          NVEC  = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] a1, a2, b1, b2;
    logic          sys_rst, busy, done;

    systolic_feeder_if #(.DW(DW)) ld ();

    systolic_feeder #(.DW(DW), .K(K), .DRAIN(DRAIN)) dut (
        .clk     (clk),
        .rst     (rst),
        .ld      (ld),
        .a1      (a1),
        .a2      (a2),
        .b1      (b1),
        .b2      (b2),
        .sys_rst (sys_rst),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // a[i*2+k] = A[i][k], b[k*2+j] = B[k][j], c[i*2+j] = expected (A*B)[i][j]
    typedef struct packed {
        logic [3:0][15:0] a;
        logic [3:0][15:0] b;
        logic [3:0][63:0] c;
        logic [7:0]       gap;
        logic             hog;
        logic [3:0]       abort_at;
    } vec_t;

    vec_t    tbl [NVEC];
    int      checks = 0;
    int      errors = 0;
    longint unsigned qa0[$], qa1[$], qb0[$], qb1[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] a00, a01, a10, a11,
                                input logic [15:0] b00, b01, b10, b11,
                                input logic [63:0] c00, c01, c10, c11,
                                input int gap, input bit hog, input int abort_at);
        vec_t v;
        v.a = {a11, a10, a01, a00};
        v.b = {b11, b10, b01, b00};
        v.c = {c11, c10, c01, c00};
        v.gap = 8'(gap);
        v.hog = hog;
        v.abort_at = 4'(abort_at);
        return v;
    endfunction

    function automatic logic [63:0] matmul_el(input vec_t v, input int i, input int j);
        logic [63:0] s;
        s = 0;
        for (int k = 0; k < K; k++) s += 64'(v.a[i*2+k]) * 64'(v.b[k*2+j]);
        return s;
    endfunction

    // Output-stationary 2x2 array: PE(i,j) at step t sees row i's input from step t-j
    // and column j's input from step t-i.
    function automatic logic [63:0] array_c(input int i, input int j);
        longint unsigned s, av, bv;
        s = 0;
        for (int t = 0; t < qa0.size(); t++) begin
            if (t - j >= 0 && t - i >= 0) begin
                av = (i == 0) ? qa0[t-j] : qa1[t-j];
                bv = (j == 0) ? qb0[t-i] : qb1[t-i];
                s += av * bv;
            end
        end
        return s;
    endfunction

    task automatic set_inputs(input logic v, input logic [15:0] x0, x1, y0, y1);
        ld.in_valid = v;
        ld.in_a0 = x0;
        ld.in_a1 = x1;
        ld.in_b0 = y0;
        ld.in_b1 = y1;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int n;
        logic [15:0] ea1, ea2, eb1, eb2;
        for (int k = 0; k < K; k++) begin
            if (k > 0) begin
                ld.in_valid = 1'b0;
                for (int g = 0; g < int'(v.gap); g++) begin
                    @(posedge clk); #1;
                    chk($sformatf("%s gap%0d in_ready", tag, g), ld.in_ready, 1);
                end
            end
            set_inputs(1'b1, v.a[k], v.a[2+k], v.b[k*2], v.b[k*2+1]);
            n = 0;
            while (ld.in_ready !== 1'b1 && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            if (n >= 50) begin
                chk($sformatf("%s ready wait timeout", tag), ld.in_ready, 1);
                return;
            end
            @(posedge clk); #1;
        end
        qa0.delete(); qa1.delete(); qb0.delete(); qb1.delete();
        for (int c = 1; c <= RUN; c++) begin
            ea1 = 0; ea2 = 0; eb1 = 0; eb2 = 0;
            if (c >= 2 && c <= K + 2) begin
                int j;
                j = c - 2;
                if (j < K)  begin ea1 = v.a[j];   eb1 = v.b[j*2];       end
                if (j >= 1) begin ea2 = v.a[1+j]; eb2 = v.b[(j-1)*2+1]; end
            end
            chk($sformatf("%s cyc%0d a1", tag, c), a1, ea1);
            chk($sformatf("%s cyc%0d a2", tag, c), a2, ea2);
            chk($sformatf("%s cyc%0d b1", tag, c), b1, eb1);
            chk($sformatf("%s cyc%0d b2", tag, c), b2, eb2);
            chk($sformatf("%s cyc%0d sys_rst", tag, c), sys_rst, (c == 1));
            chk($sformatf("%s cyc%0d busy", tag, c), busy, (c < RUN));
            chk($sformatf("%s cyc%0d done", tag, c), done, (c == RUN - 1));
            chk($sformatf("%s cyc%0d in_ready", tag, c), ld.in_ready, (c == RUN));
            if (c >= 2 && c < RUN) begin
                qa0.push_back(a1); qa1.push_back(a2);
                qb0.push_back(b1); qb1.push_back(b2);
            end
            if (c < RUN && v.hog) set_inputs(1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
            else                  ld.in_valid = 1'b0;
            if (c == int'(v.abort_at)) begin
                rst = 1'b1;
                ld.in_valid = 1'b0;
                @(posedge clk); #1;
                chk($sformatf("%s abort a1", tag), a1, 0);
                chk($sformatf("%s abort a2", tag), a2, 0);
                chk($sformatf("%s abort b1", tag), b1, 0);
                chk($sformatf("%s abort b2", tag), b2, 0);
                chk($sformatf("%s abort sys_rst", tag), sys_rst, 1);
                chk($sformatf("%s abort busy", tag), busy, 0);
                chk($sformatf("%s abort done", tag), done, 0);
                rst = 1'b0;
                #1;
                chk($sformatf("%s abort in_ready", tag), ld.in_ready, 1);
                return;
            end
            if (c < RUN) begin
                @(posedge clk); #1;
            end
        end
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                chk($sformatf("%s c[%0d][%0d]", tag, i, j), array_c(i, j), v.c[i*2+j]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = mk(1, 2, 3, 4, 5, 6, 7, 8, 19, 22, 43, 50, 0, 0, 0);
        tbl[1] = mk(1, 2, 3, 4, 5, 6, 7, 8, 19, 22, 43, 50, 4, 0, 0);
        tbl[2] = mk(1, 2, 3, 4, 5, 6, 7, 8, 19, 22, 43, 50, 0, 1, 0);
        tbl[3] = mk(1, 2, 3, 4, 5, 6, 7, 8, 19, 22, 43, 50, 0, 0, 3);
        tbl[4] = mk(1, 0, 0, 1, 9, 8, 7, 6, 9, 8, 7, 6, 0, 0, 0);
        tbl[5] = mk(16'hFFFF, 0, 0, 0, 5, 6, 7, 8, 64'h4FFFB, 64'h5FFFA, 0, 0, 0, 0, 0);
        tbl[6] = mk(1, 2, 3, 4, 5, 6, 7, 8, 19, 22, 43, 50, 0, 0, 0);
        for (int r = 7; r < NVEC; r++) begin
            tbl[r] = mk(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                        16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                        0, 0, 0, 0, int'($urandom_range(0, 3)), 1'($urandom), 0);
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 2; j++)
                    tbl[r].c[i*2+j] = matmul_el(tbl[r], i, j);
        end

        // Reset held for 3 cycles with a live-looking beat on the port.
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            set_inputs(1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            @(posedge clk); #1;
            chk($sformatf("reset%0d a1", c), a1, 0);
            chk($sformatf("reset%0d a2", c), a2, 0);
            chk($sformatf("reset%0d b1", c), b1, 0);
            chk($sformatf("reset%0d b2", c), b2, 0);
            chk($sformatf("reset%0d sys_rst", c), sys_rst, 1);
            chk($sformatf("reset%0d in_ready", c), ld.in_ready, 0);
            chk($sformatf("reset%0d done", c), done, 0);
            chk($sformatf("reset%0d busy", c), busy, 0);
        end
        rst = 1'b0;
        ld.in_valid = 1'b0;
        #1;
        chk("post-reset in_ready", ld.in_ready, 1);

        for (int r = 0; r < NVEC; r++) run_vec(tbl[r], $sformatf("vec%0d", r));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Upstream staging block for the 2x2 output-stationary systolic array (`sys`). It buffers one pair of operand matrices (A: 2xK, B: Kx2) delivered over a valid/ready stream. It then clears the array's accumulators and drives the array's `a1/a2/b1/b2` inputs with the row/column skew the array requires. After the fill and drain time it pulses `done`, at which point the array's `c` outputs hold A·B.

## Interface
- `DW`, 16, data width of every operand element and array input
- `K`, 2, inner dimension (beats per load, >=1)
- `DRAIN`, 3, zero-input cycles after the last feed step, before `done`
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset; one clock; reset is synchronous and active-high
- `in_valid`  in  1  load beat valid
- `in_ready`  out  1  block accepts a beat this cycle
- `in_a0`  in  DW  A[0][k]
- `in_a1`  in  DW  A[1][k]
- `in_b0`  in  DW  B[k][0]
- `in_b1`  in  DW  B[k][1]
- `a1`, `a2`  out  DW  array row inputs (row 0, row 1)
- `b1`, `b2`  out  DW  array column inputs (col 0, col 1)
- `sys_rst`  out  1  drives array `rst`; clears accumulators
- `busy`  out  1  high from CLEAR through DONE
- `done`  out  1  one-cycle pulse; array result valid

## Operation
- States: LOAD, CLEAR, FEED, DRAIN, DONE.
- Reset (`rst`=1 at an edge): state←LOAD, beat/step counters←0, buffers←0, `a1/a2/b1/b2`←0, `done`←0, `busy`←0, `sys_rst`←1.
- `rst` mid-operation aborts any state with the same reset values. A partial load is discarded.
- LOAD:
  - `in_ready`=1, `sys_rst`=0.
  - Each handshake (`in_valid & in_ready`) stores beat k into buffer slot k (k = 0..K-1, arrival order).
  - On the K-th handshake the next state is CLEAR.
- CLEAR: exactly 1 cycle; `sys_rst`=1, all data outputs 0. Next state FEED, step j=0.
- FEED: K+1 cycles, step j = 0..K. Values in step j:
  - `a1` = A[0][j] if j<K, else 0
  - `a2` = A[1][j-1] if j>=1, else 0
  - `b1` = B[j][0] if j<K, else 0
  - `b2` = B[j-1][1] if j>=1, else 0
  - After j=K, next state is DRAIN.
- DRAIN: DRAIN cycles with all data outputs 0. Next state DONE.
- DONE: 1 cycle; `done`=1, outputs 0. Next state LOAD. Buffers are not cleared; they are overwritten by the next load.
- `in_ready`=0 outside LOAD. `in_valid` in other states is ignored and nothing is stored.
- No arithmetic is performed: elements pass through bit-exact at width DW.
- `busy` = (state != LOAD).

## Timing
- All outputs are registered, except `in_ready`, which is decoded from the registered state.
- The data outputs in a given cycle are the values for the current state and step.
- Cycle numbering, with edge 0 the edge that accepts the last beat:
  - cycle 1: CLEAR
  - cycles 2..K+2: FEED steps 0..K
  - cycles K+3..K+2+DRAIN: DRAIN
  - cycle K+3+DRAIN: DONE
  - cycle K+4+DRAIN: LOAD, `in_ready`=1
- With the defaults (K=2, DRAIN=3): `done` in cycle 8, next beat accepted no earlier than cycle 9.
- Back-to-back beats are accepted every cycle in LOAD. `in_valid` gaps stall the load indefinitely.
- `sys_rst` is high in CLEAR and for every cycle `rst` is high; low otherwise.

## Test plan
- Reset: hold `rst` for 3 cycles, with `in_valid`=1 and random data on the beat ports -> all data outputs 0, `sys_rst`=1, `in_ready`=0, `done`=0; after release `in_ready`=1 and nothing has been stored.
- Basic load with A=[[1,2],[3,4]], B=[[5,6],[7,8]]: beats (a0,a1,b0,b1) = (1,3,5,6) then (2,4,7,8).
  - FEED steps: (a1,a2,b1,b2) = (1,0,5,0), (2,3,7,6), (0,4,0,8).
  - `done` in cycle 8.
  - Connected `sys` gives c = [[19,22],[43,50]].
- Gappy input: same beats with `in_valid` low for 4 cycles between them -> identical FEED sequence; `done` 8 cycles after the second accept.
- Busy blocking: hold `in_valid`=1 with 0xFFFF data throughout FEED and DRAIN -> no capture, `in_ready`=0, FEED values unchanged.
- Mid-feed reset: assert `rst` during FEED step 1 -> next cycle all outputs 0, state LOAD; a fresh load of A=I, B=[[9,8],[7,6]] yields c = [[9,8],[7,6]].
- Back-to-back: two loads separated only by DONE -> second CLEAR pulses `sys_rst`, and the second result is independent of the first (A=[[0xFFFF,0],[0,0]] leaves no residue).
